// File: rtl/vector_compare_unit.sv
// Integer compare stage of the vector execution pipeline.
// Compares one 64-bit slice of vs2 against vs1 element-wise at SEW 8/16/32/64 and
// registers a per-element mask byte (bit i = result for element i) for mask writeback.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   valid_i      operands/op valid this cycle
//   cmp_op_i     000 EQ, 001 NE, 010 LTU, 011 LT, 100 LEU, 101 LE, 110 GTU, 111 GT
//   sew_i        00=8, 01=16, 10=32, 11=64 bits per element
//   vs2_i        left operand  (element i = bits [i*SEW +: SEW])
//   vs1_i        right operand (scalar/imm already splatted)
//   vd_o         result mask, bits above the element count are zero
//   vd_valid_o   vd_o holds a fresh result
module vector_compare_unit #(
  parameter int unsigned Elen      = 64,
  parameter int unsigned MaskWidth = Elen / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  input  logic [2:0]           cmp_op_i,
  input  logic [1:0]           sew_i,
  input  logic [Elen-1:0]      vs2_i,
  input  logic [Elen-1:0]      vs1_i,
  output logic [MaskWidth-1:0] vd_o,
  output logic                 vd_valid_o
);

  localparam int unsigned NumLanes = Elen / 8;

  logic [NumLanes-1:0] first_mask;  // lane holds the LSB byte of an element
  logic [NumLanes-1:0] top_mask;    // lane holds the MSB byte of an element
  logic                signed_cmp;
  logic [NumLanes-1:0] lane_eq;
  logic [NumLanes-1:0] lane_lt;
  logic [NumLanes-1:0] chain_eq;
  logic [NumLanes-1:0] chain_lt;
  logic [NumLanes-1:0] lane_res;
  logic [MaskWidth-1:0] vd_d, vd_q;
  logic                 vd_valid_q;

  always_comb begin
    unique case (sew_i)
      2'b00: begin first_mask = 8'hFF; top_mask = 8'hFF; end
      2'b01: begin first_mask = 8'h55; top_mask = 8'hAA; end
      2'b10: begin first_mask = 8'h11; top_mask = 8'h88; end
      default: begin first_mask = 8'h01; top_mask = 8'h80; end
    endcase
  end

  // EQ/NE ignore signedness: flipping both MSBs never changes equality.
  assign signed_cmp = cmp_op_i[0];

  // Per-lane byte compare; signed elements get their MSB inverted so an unsigned
  // compare yields the two's-complement ordering.
  always_comb begin
    lane_eq = '0;
    lane_lt = '0;
    for (int k = 0; k < NumLanes; k++) begin
      logic [7:0] a_b;
      logic [7:0] b_b;
      a_b = vs2_i[8*k +: 8];
      b_b = vs1_i[8*k +: 8];
      if (signed_cmp && top_mask[k]) begin
        a_b[7] = ~a_b[7];
        b_b[7] = ~b_b[7];
      end
      lane_eq[k] = (a_b == b_b);
      lane_lt[k] = (a_b < b_b);
    end
  end

  // Chain from LSB lane upward inside each element: a higher lane decides unless it
  // is equal, in which case the lower lanes' verdict carries through.
  always_comb begin
    logic lt_run;
    logic eq_run;
    lt_run   = 1'b0;
    eq_run   = 1'b1;
    chain_eq = '0;
    chain_lt = '0;
    for (int k = 0; k < NumLanes; k++) begin
      if (first_mask[k]) begin
        lt_run = lane_lt[k];
        eq_run = lane_eq[k];
      end else begin
        lt_run = lane_lt[k] | (lane_eq[k] & lt_run);
        eq_run = lane_eq[k] & eq_run;
      end
      chain_lt[k] = lt_run;
      chain_eq[k] = eq_run;
    end
  end

  // Only lanes flagged in top_mask carry a complete element result.
  always_comb begin
    lane_res = '0;
    for (int k = 0; k < NumLanes; k++) begin
      unique case (cmp_op_i[2:1])
        2'b00:   lane_res[k] = cmp_op_i[0] ? ~chain_eq[k] : chain_eq[k];
        2'b01:   lane_res[k] = chain_lt[k];
        2'b10:   lane_res[k] = chain_lt[k] | chain_eq[k];
        default: lane_res[k] = ~(chain_lt[k] | chain_eq[k]);
      endcase
    end
  end

  // Compact element results (top lanes) into the low mask bits; upper bits zero.
  always_comb begin
    vd_d = '0;
    unique case (sew_i)
      2'b00:   vd_d = lane_res;
      2'b01:   vd_d = {4'b0, lane_res[7], lane_res[5], lane_res[3], lane_res[1]};
      2'b10:   vd_d = {6'b0, lane_res[7], lane_res[3]};
      default: vd_d = {7'b0, lane_res[7]};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vd_q       <= '0;
      vd_valid_q <= 1'b0;
    end else begin
      vd_valid_q <= valid_i;
      if (valid_i) begin
        vd_q <= vd_d;
      end
    end
  end

  assign vd_o       = vd_q;
  assign vd_valid_o = vd_valid_q;

endmodule

// File: tb/tb_vector_compare_unit.sv
module tb_vector_compare_unit;

  logic        clk_i;
  logic        rst_ni;
  logic        valid_i;
  logic [2:0]  cmp_op_i;
  logic [1:0]  sew_i;
  logic [63:0] vs2_i;
  logic [63:0] vs1_i;
  logic [7:0]  vd_o;
  logic        vd_valid_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [2:0] OpEq = 3'b000, OpNe = 3'b001, OpLtu = 3'b010, OpLt = 3'b011;
  localparam logic [2:0] OpLeu = 3'b100, OpLe = 3'b101, OpGtu = 3'b110, OpGt = 3'b111;

  vector_compare_unit dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .cmp_op_i   (cmp_op_i),
    .sew_i      (sew_i),
    .vs2_i      (vs2_i),
    .vs1_i      (vs1_i),
    .vd_o       (vd_o),
    .vd_valid_o (vd_valid_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Arithmetic reference: extract, sign-extend via shifts, compare as integers.
  function automatic logic [7:0] model(input logic [2:0] op, input logic [1:0] sew,
                                       input logic [63:0] a, input logic [63:0] b);
    logic [7:0] r;
    int w, n;
    logic [63:0] ea, eb;
    longint sa, sb;
    logic res;
    r = 8'h00;
    w = 8 << sew;
    n = 64 / w;
    for (int e = 0; e < n; e++) begin
      ea = a >> (e * w);
      eb = b >> (e * w);
      if (w < 64) begin
        ea = ea & ((64'd1 << w) - 64'd1);
        eb = eb & ((64'd1 << w) - 64'd1);
      end
      sa = longint'(ea << (64 - w)) >>> (64 - w);
      sb = longint'(eb << (64 - w)) >>> (64 - w);
      case (op)
        OpEq:    res = (ea == eb);
        OpNe:    res = (ea != eb);
        OpLtu:   res = (ea < eb);
        OpLt:    res = (sa < sb);
        OpLeu:   res = (ea <= eb);
        OpLe:    res = (sa <= sb);
        OpGtu:   res = (ea > eb);
        default: res = (sa > sb);
      endcase
      r[e] = res;
    end
    return r;
  endfunction

  task automatic apply(input logic [2:0] op, input logic [1:0] sew,
                       input logic [63:0] a, input logic [63:0] b);
    @(negedge clk_i);
    valid_i  = 1'b1;
    cmp_op_i = op;
    sew_i    = sew;
    vs2_i    = a;
    vs1_i    = b;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b1;
    cmp_op_i = OpEq;
    sew_i   = 2'b00;
    vs2_i   = 64'h0;
    vs1_i   = 64'h0;
    repeat (2) @(posedge clk_i);
    #1;
    total_cnt++;
    if (vd_o !== 8'h00 || vd_valid_o !== 1'b0)
      $display("FAIL reset_state: vd=%h valid=%b, required vd=00 valid=0", vd_o, vd_valid_o);
    else pass_cnt++;
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_ni  = 1'b1;
  endtask

  task automatic test_eq_ne();
    apply(OpEq, 2'b00, 64'h0011223344556677, 64'h0011FF33445566AA);
    total_cnt++;
    if (vd_o !== 8'hDE || vd_valid_o !== 1'b1)
      $display("FAIL eq_sew8: vd=%h valid=%b, required vd=de valid=1", vd_o, vd_valid_o);
    else pass_cnt++;
    apply(OpNe, 2'b00, 64'h0011223344556677, 64'h0011FF33445566AA);
    total_cnt++;
    if (vd_o !== 8'h21)
      $display("FAIL ne_sew8: vd=%h, required 21", vd_o);
    else pass_cnt++;
  endtask

  task automatic test_lt();
    apply(OpLtu, 2'b10, 64'hFFFFFFFF_00000001, 64'h00000001_00000002);
    total_cnt++;
    if (vd_o !== 8'h01) $display("FAIL ltu_sew32: vd=%h, required 01", vd_o);
    else pass_cnt++;
    apply(OpLt, 2'b10, 64'hFFFFFFFF_00000001, 64'h00000001_00000002);
    total_cnt++;
    if (vd_o !== 8'h03) $display("FAIL lt_sew32: vd=%h, required 03", vd_o);
    else pass_cnt++;
  endtask

  task automatic test_gt();
    apply(OpGt, 2'b01, 64'h8000_7FFF_0005_0005, 64'h7FFF_8000_0005_0004);
    total_cnt++;
    if (vd_o !== 8'h05) $display("FAIL gt_sew16: vd=%h, required 05", vd_o);
    else pass_cnt++;
    apply(OpGtu, 2'b01, 64'h8000_7FFF_0005_0005, 64'h7FFF_8000_0005_0004);
    total_cnt++;
    if (vd_o !== 8'h09) $display("FAIL gtu_sew16: vd=%h, required 09", vd_o);
    else pass_cnt++;
  endtask

  task automatic test_sew64_equal();
    // Per-op expectation for equal operands, indexed by cmp_op.
    logic [7:0] exp_tab;
    exp_tab = 8'b0011_0001;  // EQ, LEU, LE true
    for (int op = 0; op < 8; op++) begin
      apply(3'(op), 2'b11, 64'h8000000000000000, 64'h8000000000000000);
      total_cnt++;
      if (vd_o !== {7'b0, exp_tab[op]})
        $display("FAIL sew64_equal op%0d: vd=%h, required %h", op, vd_o, {7'b0, exp_tab[op]});
      else pass_cnt++;
    end
    // Signed min vs max: signed and unsigned must disagree.
    apply(OpLt, 2'b11, 64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF);
    total_cnt++;
    if (vd_o !== 8'h01) $display("FAIL min_max_lt: vd=%h, required 01", vd_o);
    else pass_cnt++;
    apply(OpLtu, 2'b11, 64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF);
    total_cnt++;
    if (vd_o !== 8'h00) $display("FAIL min_max_ltu: vd=%h, required 00", vd_o);
    else pass_cnt++;
    apply(OpLt, 2'b00, 64'h8080808080808080, 64'h7F7F7F7F7F7F7F7F);
    total_cnt++;
    if (vd_o !== 8'hFF) $display("FAIL min_max_lt_sew8: vd=%h, required ff", vd_o);
    else pass_cnt++;
  endtask

  task automatic test_valid_pulse();
    apply(OpEq, 2'b00, 64'h0011223344556677, 64'h0011FF33445566AA);
    total_cnt++;
    if (vd_o !== 8'hDE || vd_valid_o !== 1'b1)
      $display("FAIL pulse_capture: vd=%h valid=%b, required vd=de valid=1", vd_o, vd_valid_o);
    else pass_cnt++;
    @(negedge clk_i);
    valid_i = 1'b0;
    vs2_i   = 64'h0;
    vs1_i   = 64'h1;
    cmp_op_i = OpNe;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk_i);
      #1;
      total_cnt++;
      if (vd_o !== 8'hDE || vd_valid_o !== 1'b0)
        $display("FAIL pulse_hold cyc%0d: vd=%h valid=%b, required vd=de valid=0",
                 c, vd_o, vd_valid_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    apply(OpEq, 2'b00, 64'h0011223344556677, 64'h0011FF33445566AA);
    total_cnt++;
    if (vd_o !== 8'hDE) $display("FAIL pre_reset: vd=%h, required de", vd_o);
    else pass_cnt++;
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    total_cnt++;
    if (vd_o !== 8'h00 || vd_valid_o !== 1'b0)
      $display("FAIL async_reset: vd=%h valid=%b, required vd=00 valid=0", vd_o, vd_valid_o);
    else pass_cnt++;
    @(posedge clk_i);
    #1;
    total_cnt++;
    if (vd_o !== 8'h00 || vd_valid_o !== 1'b0)
      $display("FAIL reset_held: vd=%h valid=%b, required vd=00 valid=0", vd_o, vd_valid_o);
    else pass_cnt++;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    total_cnt++;
    if (vd_o !== 8'hDE || vd_valid_o !== 1'b1)
      $display("FAIL post_reset_capture: vd=%h valid=%b, required vd=de valid=1",
               vd_o, vd_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    apply(OpGt, 2'b01, 64'h8000_7FFF_0005_0005, 64'h7FFF_8000_0005_0004);
    total_cnt++;
    if (vd_o !== 8'h05 || vd_valid_o !== 1'b1)
      $display("FAIL b2b_0: vd=%h valid=%b, required vd=05 valid=1", vd_o, vd_valid_o);
    else pass_cnt++;
    apply(OpNe, 2'b00, 64'h0011223344556677, 64'h0011FF33445566AA);
    total_cnt++;
    if (vd_o !== 8'h21 || vd_valid_o !== 1'b1)
      $display("FAIL b2b_1: vd=%h valid=%b, required vd=21 valid=1", vd_o, vd_valid_o);
    else pass_cnt++;
    apply(OpLtu, 2'b10, 64'hFFFFFFFF_00000001, 64'h00000001_00000002);
    total_cnt++;
    if (vd_o !== 8'h01 || vd_valid_o !== 1'b1)
      $display("FAIL b2b_2: vd=%h valid=%b, required vd=01 valid=1", vd_o, vd_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_random_sweep();
    logic [63:0] a, b;
    logic [7:0]  exp;
    for (int combo = 0; combo < 32; combo++) begin
      for (int it = 0; it < 4; it++) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        // Copy some bytes so equal-lane chaining gets exercised.
        for (int k = 0; k < 8; k++) begin
          if ($urandom_range(0, 1) == 1) b[8*k +: 8] = a[8*k +: 8];
        end
        if (it == 0) b = a;
        exp = model(3'(combo & 7), 2'(combo >> 3), a, b);
        apply(3'(combo & 7), 2'(combo >> 3), a, b);
        total_cnt++;
        if (vd_o !== exp || vd_valid_o !== 1'b1)
          $display("FAIL sweep op%0d sew%0d a=%h b=%h: vd=%h valid=%b, required vd=%h valid=1",
                   combo & 7, combo >> 3, a, b, vd_o, vd_valid_o, exp);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_eq_ne();
    test_lt();
    test_gt();
    test_sew64_equal();
    test_valid_pulse();
    test_async_reset();
    test_back_to_back();
    test_random_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
